dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one word access per handshake and holds it for LATENCY edges.
// At the edge that enters RESP it commits the store or captures the load data.
// It then pulses rsp_valid_o for one cycle.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        stall_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Request captured at the accept edge; later input changes are ignored
    logic             lat_write;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;

    // Access point decode: with LATENCY=1 the access happens at the accept edge
    // itself, so the live inputs are used instead of the latched copy.
    always_comb begin
        accept     = (state == IDLE) && req_valid_i;
        enter_resp = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == '0));
        if (state == IDLE) begin
            acc_write = req_write_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_write = lat_write;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
        acc_idx = acc_addr[IDX_W+1:2];
        acc_err = (|acc_addr[1:0]) || (|acc_addr[31:IDX_W+2]);
    end

    // Pipeline may advance only in the RESP cycle
    assign stall_o = req_valid_i && (state != RESP);

    // Capture the request fields at the accept edge
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lat_write <= req_write_i;
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
        end
    end

    // Word array: stores commit only at the access point and never while in reset
    always_ff @(posedge clk_i) begin
        if (rst_n && enter_resp && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= acc_err;
                rsp_rdata_o <= (acc_write || acc_err) ? 32'h0 : mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance.
// A word-array reference model predicts load data and error flags.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v1, v2, w;
    logic [31:0] a, d;
    logic        r1, s1, rv1, e1;
    logic        r2, s2, rv2, e2;
    logic [31:0] rd1, rd2;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut2 (
        .clk_i(clk), .rst_n(rst_n), .req_valid_i(v2), .req_write_i(w),
        .req_addr_i(a), .req_wdata_i(d), .req_ready_o(r2), .stall_o(s2),
        .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .rsp_err_o(e2));

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_n(rst_n), .req_valid_i(v1), .req_write_i(w),
        .req_addr_i(a), .req_wdata_i(d), .req_ready_o(r1), .stall_o(s1),
        .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(e1));

    int cur = 2;
    wire        c_rv = (cur == 1) ? rv1 : rv2;
    wire        c_s  = (cur == 1) ? s1  : s2;
    wire        c_r  = (cur == 1) ? r1  : r2;
    wire [31:0] c_rd = (cur == 1) ? rd1 : rd2;
    wire        c_e  = (cur == 1) ? e1  : e2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model [128];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vt [9];

    function automatic logic [31:0] fillv(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One handshake on the selected instance; returns the response and the cycle it arrived
    task automatic do_req(input int sel, input logic wr, input logic [31:0] ad,
                          input logic [31:0] dt, input bit keep,
                          output logic [31:0] rd, output logic er, output int rc);
        int lat;
        int n;
        lat = (sel == 1) ? 1 : 2;
        n = 0;
        cur = sel;
        w = wr; a = ad; d = dt;
        if (sel == 1) v1 = 1'b1; else v2 = 1'b1;
        #1;
        chk("ready_idle", c_r, 1);
        chk("stall_req", c_s, 1);
        do begin
            @(posedge clk); #1;
            n++;
            if (!c_rv) begin
                chk("stall_busy", c_s, 1);
                chk("ready_busy", c_r, 0);
            end
        end while (!c_rv && n < 10);
        chk("rsp_latency", n, lat);
        chk("stall_resp", c_s, 0);
        chk("ready_resp", c_r, 0);
        rd = c_rd; er = c_e; rc = cyc;
        if (!keep) begin v1 = 1'b0; v2 = 1'b0; end
        @(posedge clk); #1;
        chk("rsp_one_pulse", c_rv, 0);
        chk("ready_back", c_r, 1);
    endtask

    // Reference: apply one access to the word model and return expected response
    task automatic model_access(input logic wr, input logic [31:0] ad, input logic [31:0] dt,
                                output logic [31:0] erd, output logic eer);
        eer = (ad[1:0] != 2'b00) || (ad >= 32'd512);
        erd = (wr || eer) ? 32'h0 : model[ad / 4];
        if (wr && !eer) model[ad / 4] = dt;
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          rc, rc_prev;
        logic [31:0] ad, dt;
        logic        wr;
        int          kind;

        v1 = 0; v2 = 0; w = 0; a = 0; d = 0;

        vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
        vt[3] = '{1'b1, 32'h22,  32'h5,        32'h0,        1'b1};
        vt[4] = '{1'b0, 32'h20,  32'h0,        fillv(8),     1'b0};
        vt[5] = '{1'b0, 32'h200, 32'h0,        32'h0,        1'b1};
        vt[6] = '{1'b0, 32'h1FC, 32'h0,        fillv(127),   1'b0};
        vt[7] = '{1'b1, 32'h1FC, 32'hCAFEF00D, 32'h0,        1'b0};
        vt[8] = '{1'b0, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0};

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready2", r2, 1);  chk("rst_valid2", rv2, 0);
        chk("rst_rdata2", rd2, 0); chk("rst_err2", e2, 0);
        chk("rst_stall2", s2, 0);
        chk("rst_ready1", r1, 1);  chk("rst_valid1", rv1, 0);
        chk("rst_rdata1", rd1, 0); chk("rst_err1", e1, 0);
        chk("rst_stall1", s1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value
        for (int i = 0; i < 128; i++) begin
            do_req(2, 1'b1, 32'(i * 4), fillv(i), 1'b0, rd, er, rc);
            model[i] = fillv(i);
            chk("fill_err", er, 0);
            chk("fill_rdata", rd, 0);
        end

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            do_req(2, vt[i].wr, vt[i].addr, vt[i].data, 1'b0, rd, er, rc);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), er, vt[i].exp_err);
            model_access(vt[i].wr, vt[i].addr, vt[i].data, erd, eer);
        end

        // Back-to-back stores with req_valid held high: one access per 3 cycles
        rc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_req(2, 1'b1, 32'h40 + 32'(i * 4), 32'h1111_0000 + 32'(i), (i < 2), rd, er, rc);
            model_access(1'b1, 32'h40 + 32'(i * 4), 32'h1111_0000 + 32'(i), erd, eer);
            if (i > 0) chk("b2b_spacing", rc - rc_prev, 3);
            rc_prev = rc;
        end
        for (int i = 0; i < 3; i++) begin
            do_req(2, 1'b0, 32'h40 + 32'(i * 4), 32'h0, 1'b0, rd, er, rc);
            chk("b2b_readback", rd, 32'h1111_0000 + 32'(i));
        end

        // Randomized accesses against the word model
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            wr = 1'($urandom_range(0, 1));
            dt = $urandom;
            if (kind == 0)      ad = 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
            else if (kind == 1) ad = 32'd512 + 32'($urandom_range(0, 4000));
            else                ad = 32'($urandom_range(0, 127) * 4);
            model_access(wr, ad, dt, erd, eer);
            do_req(2, wr, ad, dt, 1'b0, rd, er, rc);
            chk("rand_rdata", rd, erd);
            chk("rand_err", er, eer);
        end

        // Reset while a store is in BUSY: store discarded, outputs cleared
        do_req(2, 1'b0, 32'h1FC, 32'h0, 1'b0, rd, er, rc);
        chk("pre_rst_load", rd, model[127]);
        w = 1'b1; a = 32'h8; d = 32'h1234; v2 = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy_ready", r2, 0);
        rst_n = 1'b0; v2 = 1'b0;
        #1;
        chk("midrst_valid", rv2, 0);
        chk("midrst_rdata", rd2, 0);
        chk("midrst_err", e2, 0);
        chk("midrst_ready", r2, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(2, 1'b0, 32'h8, 32'h0, 1'b0, rd, er, rc);
        chk("midrst_store_dropped", rd, model[2]);

        // LATENCY=1 instance
        do_req(1, 1'b1, 32'h30, 32'h0000_0077, 1'b0, rd, er, rc);
        chk("lat1_store_rdata", rd, 0);
        chk("lat1_store_err", er, 0);
        do_req(1, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, rc);
        chk("lat1_load_rdata", rd, 32'h77);
        do_req(1, 1'b0, 32'h31, 32'h0, 1'b0, rd, er, rc);
        chk("lat1_misal_err", er, 1);
        chk("lat1_misal_rdata", rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
